bus_dma: RTL and testbench

Single-channel word-copy engine that acts as an initiator on the native valid/ready memory bus used by the SoC peripherals. It reads `len` 32-bit words starting at a source address and writes them to a destination address, one transaction at a time, with a per-transaction timeout. It sits beside the CPU on the bus interconnect and is commanded through a start/done sideband interface.

---
 rtl/bus_dma_pkg.sv | 21 ++
 rtl/bus_init_port.sv | 74 +++++++
 rtl/bus_dma.sv | 152 +++++++++++++++
 tb/tb_bus_dma.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_dma_pkg.sv
// Shared types and constants for the bus_dma word-copy engine.
package bus_dma_pkg;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StRd    = 3'd1,
    StRdGap = 3'd2,
    StWr    = 3'd3,
    StWrGap = 3'd4,
    StFin   = 3'd5
  } state_e;

  localparam logic [3:0]  WSTRB_RD   = 4'h0;
  localparam logic [3:0]  WSTRB_WR   = 4'hF;
  localparam logic [31:0] WORD_BYTES = 32'd4;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/bus_init_port.sv
// Single-transaction bus initiator: holds the request stable while valid is high,
// and reports handshake completion or timeout as single-cycle pulses.
module bus_init_port #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        req_i,
  input  logic [31:0] req_addr_i,
  input  logic [3:0]  req_wstrb_i,
  input  logic [31:0] req_wdata_i,
  output logic        ack_o,
  output logic        tmo_o,
  output logic        mem_valid_o,
  input  logic        mem_ready_i,
  output logic [31:0] mem_addr_o,
  output logic [3:0]  mem_wstrb_o,
  output logic [31:0] mem_wdata_o
);

  // Timeout fires on the edge that would bring the wait count up to TIMEOUT.
  localparam logic [15:0] TmoLast = 16'(TIMEOUT - 1);

  logic        valid_q, valid_d;
  logic [15:0] cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [31:0] wdata_q, wdata_d;

  assign ack_o = valid_q & mem_ready_i;
  assign tmo_o = valid_q & ~mem_ready_i & (cnt_q == TmoLast);

  always_comb begin
    valid_d = valid_q;
    addr_d  = addr_q;
    wstrb_d = wstrb_q;
    wdata_d = wdata_q;
    if (req_i) begin
      valid_d = 1'b1;
      addr_d  = req_addr_i;
      wstrb_d = req_wstrb_i;
      wdata_d = req_wdata_i;
    end else if (ack_o || tmo_o) begin
      valid_d = 1'b0;
    end
    if (!valid_q || ack_o || tmo_o) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      valid_q <= 1'b0;
      cnt_q   <= '0;
      addr_q  <= '0;
      wstrb_q <= '0;
      wdata_q <= '0;
    end else begin
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wstrb_q <= wstrb_d;
      wdata_q <= wdata_d;
    end
  end

  assign mem_valid_o = valid_q;
  assign mem_addr_o  = addr_q;
  assign mem_wstrb_o = wstrb_q;
  assign mem_wdata_o = wdata_q;

endmodule

// File: rtl/bus_dma.sv
// Single-channel word-copy DMA: sequences read/write transactions through bus_init_port,
// with a mandatory idle gap after each handshake.
module bus_dma
  import bus_dma_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned LEN_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [31:0]      src_addr,
  input  logic [31:0]      dst_addr,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [LEN_W-1:0] words_done,
  output logic             mem_valid,
  input  logic             mem_ready,
  output logic [31:0]      mem_addr,
  output logic [3:0]       mem_wstrb,
  output logic [31:0]      mem_wdata,
  input  logic [31:0]      mem_rdata
);

  state_e           state_q, state_d;
  logic [31:0]      src_q, src_d, dst_q, dst_d, data_q, data_d;
  logic [LEN_W-1:0] rem_q, rem_d, words_q, words_d;
  logic             busy_q, busy_d, done_q, done_d, err_q, err_d;

  logic             req, ack, tmo;
  logic [31:0]      req_addr;
  logic [3:0]       req_wstrb;

  // Requests are issued on the edge entering RD/WR so valid is registered at the port.
  always_comb begin
    state_d   = state_q;
    src_d     = src_q;
    dst_d     = dst_q;
    data_d    = data_q;
    rem_d     = rem_q;
    words_d   = words_q;
    err_d     = err_q;
    req       = 1'b0;
    req_addr  = src_q;
    req_wstrb = WSTRB_RD;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          err_d   = 1'b0;
          words_d = '0;
          if (len != '0) begin
            src_d    = word_align(src_addr);
            dst_d    = word_align(dst_addr);
            rem_d    = len;
            req      = 1'b1;
            req_addr = word_align(src_addr);
            state_d  = StRd;
          end else begin
            state_d = StFin;
          end
        end
      end
      StRd: begin
        if (tmo) begin
          err_d   = 1'b1;
          state_d = StFin;
        end else if (ack) begin
          data_d  = mem_rdata;
          state_d = StRdGap;
        end
      end
      StRdGap: begin
        req       = 1'b1;
        req_addr  = dst_q;
        req_wstrb = WSTRB_WR;
        state_d   = StWr;
      end
      StWr: begin
        if (tmo) begin
          err_d   = 1'b1;
          state_d = StFin;
        end else if (ack) begin
          src_d   = src_q + WORD_BYTES;
          dst_d   = dst_q + WORD_BYTES;
          words_d = words_q + LEN_W'(1);
          rem_d   = rem_q - LEN_W'(1);
          state_d = (rem_q == LEN_W'(1)) ? StFin : StWrGap;
        end
      end
      StWrGap: begin
        req      = 1'b1;
        req_addr = src_q;
        state_d  = StRd;
      end
      StFin:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
    busy_d = (state_d == StRd) || (state_d == StRdGap) || (state_d == StWr) ||
             (state_d == StWrGap);
    done_d = (state_d == StFin);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      src_q   <= '0;
      dst_q   <= '0;
      data_q  <= '0;
      rem_q   <= '0;
      words_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      data_q  <= data_d;
      rem_q   <= rem_d;
      words_q <= words_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  bus_init_port #(
    .TIMEOUT(TIMEOUT)
  ) u_port (
    .clk_i       (clk),
    .reset_i     (reset),
    .req_i       (req),
    .req_addr_i  (req_addr),
    .req_wstrb_i (req_wstrb),
    .req_wdata_i (data_q),
    .ack_o       (ack),
    .tmo_o       (tmo),
    .mem_valid_o (mem_valid),
    .mem_ready_i (mem_ready),
    .mem_addr_o  (mem_addr),
    .mem_wstrb_o (mem_wstrb),
    .mem_wdata_o (mem_wdata)
  );

  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;
  assign words_done = words_q;

endmodule

// File: tb/tb_bus_dma.sv
// Directed bench for bus_dma: a small responder model logs every handshake and the
// initial block checks addresses, data, counts and timing against hand-computed values.
module tb_bus_dma;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [31:0] src_addr, dst_addr;
  logic [15:0] len;
  logic        busy, done, err;
  logic [15:0] words_done;
  logic        mem_valid;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;

  always #5 clk = ~clk;

  bus_dma #(
    .TIMEOUT(8),
    .LEN_W  (16)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .src_addr  (src_addr),
    .dst_addr  (dst_addr),
    .len       (len),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .words_done(words_done),
    .mem_valid (mem_valid),
    .mem_ready (mem_ready),
    .mem_addr  (mem_addr),
    .mem_wstrb (mem_wstrb),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  int          n_checks = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          t0, done_cyc, k;
  logic [31:0] rd_log[$];
  logic [31:0] wa_log[$];
  logic [31:0] wd_log[$];
  logic        rand_en = 1'b0;
  logic        stale_en = 1'b0;
  int          block_at = -1;
  int          delay_left = 0;

  // Memory content is a fixed function of the address.
  assign mem_rdata = mem_addr ^ 32'h5A5A_0000;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_valid && mem_ready) begin
      if (mem_wstrb == 4'h0) rd_log.push_back(mem_addr);
      else begin
        wa_log.push_back(mem_addr);
        wd_log.push_back(mem_wdata);
      end
      mem_ready  <= stale_en;
      delay_left <= rand_en ? int'($urandom_range(0, 5)) : 0;
    end else if (mem_valid) begin
      if (mem_wstrb == 4'h0 && rd_log.size() == block_at) mem_ready <= 1'b0;
      else if (delay_left > 0) begin
        delay_left <= delay_left - 1;
        mem_ready  <= 1'b0;
      end else mem_ready <= 1'b1;
    end else begin
      mem_ready <= 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    rd_log.delete();
    wa_log.delete();
    wd_log.delete();
  endtask

  task automatic do_start(input logic [31:0] s, input logic [31:0] d, input logic [15:0] l);
    @(negedge clk);
    src_addr = s;
    dst_addr = d;
    len      = l;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    t0    = cyc;
  endtask

  task automatic wait_done(input int budget);
    done_cyc = -1;
    for (int i = 0; i < budget; i++) begin
      if (done) begin
        done_cyc = cyc;
        break;
      end
      @(negedge clk);
    end
    chk("done_within_budget", 32'(done_cyc >= 0), 32'd1);
  endtask

  task automatic wait_wr(input int n);
    for (int i = 0; i < 200 && wa_log.size() < n; i++) @(negedge clk);
    chk("wr_count_reached", wa_log.size(), n);
  endtask

  task automatic wait_valid(input logic [3:0] strb);
    for (int i = 0; i < 200 && !(mem_valid && mem_wstrb == strb); i++) @(negedge clk);
    chk("valid_seen", {31'd0, mem_valid}, 32'd1);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; src_addr = '0; dst_addr = '0; len = '0;
    repeat (3) @(negedge clk);
    chk("rst_mem_valid", {31'd0, mem_valid}, 32'd0);
    chk("rst_busy_done_err", {29'd0, busy, done, err}, 32'd0);
    chk("rst_words_done", {16'd0, words_done}, 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_wdata_wstrb", mem_wdata | {28'd0, mem_wstrb}, 32'd0);
    reset = 1'b0;

    // Basic copy, 1-cycle-latency responder.
    clear_logs();
    do_start(32'h100, 32'h200, 16'd3);
    chk("t1_busy_after_start", {31'd0, busy}, 32'd1);
    chk("t1_valid_after_start", {31'd0, mem_valid}, 32'd1);
    wait_done(100);
    chk("t1_cycles_valid_to_done", done_cyc - t0 + 1, 32'd18);
    chk("t1_busy_in_done", {31'd0, busy}, 32'd0);
    chk("t1_words_done", {16'd0, words_done}, 32'd3);
    chk("t1_err", {31'd0, err}, 32'd0);
    chk("t1_rd_n", rd_log.size(), 32'd3);
    chk("t1_rd0", rd_log[0], 32'h100);
    chk("t1_rd1", rd_log[1], 32'h104);
    chk("t1_rd2", rd_log[2], 32'h108);
    chk("t1_wr_n", wa_log.size(), 32'd3);
    chk("t1_wa0", wa_log[0], 32'h200);
    chk("t1_wa1", wa_log[1], 32'h204);
    chk("t1_wa2", wa_log[2], 32'h208);
    chk("t1_wd0", wd_log[0], 32'h5A5A_0100);
    chk("t1_wd1", wd_log[1], 32'h5A5A_0104);
    chk("t1_wd2", wd_log[2], 32'h5A5A_0108);
    @(negedge clk);
    chk("t1_done_one_cycle", {31'd0, done}, 32'd0);
    chk("t1_words_hold", {16'd0, words_done}, 32'd3);

    // Zero-length command: done next cycle, no bus traffic.
    clear_logs();
    do_start(32'h100, 32'h200, 16'd0);
    chk("t2_done", {31'd0, done}, 32'd1);
    chk("t2_valid", {31'd0, mem_valid}, 32'd0);
    chk("t2_words_done", {16'd0, words_done}, 32'd0);
    chk("t2_err", {31'd0, err}, 32'd0);
    @(negedge clk);
    chk("t2_done_low", {31'd0, done | mem_valid}, 32'd0);
    chk("t2_no_traffic", rd_log.size() + wa_log.size(), 32'd0);

    // Address wrap, low address bits ignored.
    clear_logs();
    do_start(32'hFFFF_FFFB, 32'h0000_0013, 16'd3);
    wait_done(100);
    chk("t3_rd0", rd_log[0], 32'hFFFF_FFF8);
    chk("t3_rd1", rd_log[1], 32'hFFFF_FFFC);
    chk("t3_rd2", rd_log[2], 32'h0000_0000);
    chk("t3_wa0", wa_log[0], 32'h0000_0010);
    chk("t3_wa2", wa_log[2], 32'h0000_0018);
    chk("t3_wd0", wd_log[0], 32'hA5A5_FFF8);
    chk("t3_wd2", wd_log[2], 32'h5A5A_0000);

    // Second read never acknowledged: abort after 8 cycles of valid.
    clear_logs();
    block_at = 1;
    do_start(32'h300, 32'h400, 16'd3);
    wait_wr(1);
    wait_valid(4'h0);
    k = 0;
    while (mem_valid && k < 100) begin
      k++;
      @(negedge clk);
    end
    chk("t4_valid_cycles", k, 32'd8);
    chk("t4_done_at_fall", {31'd0, done}, 32'd1);
    chk("t4_err", {31'd0, err}, 32'd1);
    chk("t4_words_done", {16'd0, words_done}, 32'd1);
    chk("t4_busy", {31'd0, busy}, 32'd0);
    chk("t4_rd_n", rd_log.size(), 32'd1);
    block_at = -1;
    @(negedge clk);
    chk("t4_err_holds", {31'd0, err}, 32'd1);

    // Random ready delays, stale ready after each handshake, ignored mid-transfer start.
    clear_logs();
    rand_en  = 1'b1;
    stale_en = 1'b1;
    do_start(32'h1000, 32'h2000, 16'd4);
    chk("t5_err_cleared", {31'd0, err}, 32'd0);
    repeat (4) @(negedge clk);
    src_addr = 32'hDEAD_0000; dst_addr = 32'hBEEF_0000; len = 16'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(400);
    chk("t5_words_done", {16'd0, words_done}, 32'd4);
    chk("t5_err", {31'd0, err}, 32'd0);
    chk("t5_rd_n", rd_log.size(), 32'd4);
    chk("t5_wr_n", wa_log.size(), 32'd4);
    for (int i = 0; i < 4; i++) begin
      chk("t5_rd", rd_log[i], 32'h1000 + 32'(4 * i));
      chk("t5_wa", wa_log[i], 32'h2000 + 32'(4 * i));
      chk("t5_wd", wd_log[i], (32'h1000 + 32'(4 * i)) ^ 32'h5A5A_0000);
    end
    repeat (10) @(negedge clk);
    chk("t5_no_extra_traffic", rd_log.size() + wa_log.size(), 32'd8);
    chk("t5_idle_busy", {31'd0, busy}, 32'd0);
    rand_en  = 1'b0;
    stale_en = 1'b0;

    // Reset during the second write, then a clean transfer.
    clear_logs();
    do_start(32'h500, 32'h600, 16'd3);
    wait_wr(1);
    wait_valid(4'hF);
    reset = 1'b1;
    @(negedge clk);
    chk("t6_valid_after_rst", {31'd0, mem_valid}, 32'd0);
    chk("t6_busy_after_rst", {31'd0, busy}, 32'd0);
    chk("t6_words_after_rst", {16'd0, words_done}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    clear_logs();
    do_start(32'h700, 32'h800, 16'd2);
    wait_done(100);
    chk("t6_words_done", {16'd0, words_done}, 32'd2);
    chk("t6_err", {31'd0, err}, 32'd0);
    chk("t6_wr_n", wa_log.size(), 32'd2);
    chk("t6_wa1", wa_log[1], 32'h804);
    chk("t6_wd1", wd_log[1], 32'h5A5A_0704);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
